// File: rtl/neuron_lut_loader_if.sv
// Config-stream and lookup signals of the runtime-loadable neuron LUT.
// The master side feeds config beats and lookups; the slave side is the LUT.
interface neuron_lut_loader_if #(
  parameter int unsigned IN_BITS  = 6,
  parameter int unsigned OUT_BITS = 2
);
  logic                cfg_start;
  logic                cfg_valid;
  logic                cfg_ready;
  logic [OUT_BITS-1:0] cfg_data;
  logic                cfg_last;
  logic                cfg_error;
  logic                table_ready;
  logic [IN_BITS-1:0]  M0;
  logic                M0_valid;
  logic [OUT_BITS-1:0] M1;
  logic                M1_valid;

  modport master (
    output cfg_start, cfg_valid, cfg_data, cfg_last, M0, M0_valid,
    input  cfg_ready, cfg_error, table_ready, M1, M1_valid
  );

  modport slave (
    input  cfg_start, cfg_valid, cfg_data, cfg_last, M0, M0_valid,
    output cfg_ready, cfg_error, table_ready, M1, M1_valid
  );
endinterface

// File: rtl/neuron_lut_loader.sv
// Runtime-programmable neuron truth table: streamed in-order load of all
// 2^IN_BITS entries, then registered one-cycle lookups while the table is complete.
module neuron_lut_loader #(
  parameter int unsigned IN_BITS  = 6,
  parameter int unsigned OUT_BITS = 2
) (
  input logic                clk,
  input logic                rst_n,
  neuron_lut_loader_if.slave bus
);
  localparam int unsigned DEPTH = 2 ** IN_BITS;

  typedef enum logic [1:0] {EMPTY, LOADING, READY} state_t;

  state_t              state_q;
  logic [IN_BITS-1:0]  idx_q;
  logic                err_q;
  logic [OUT_BITS-1:0] m1_q;
  logic                m1_valid_q;
  logic [OUT_BITS-1:0] table_q [DEPTH];
  logic                accept;

  // Start has priority over a beat presented in the same cycle.
  assign bus.cfg_ready   = (state_q == LOADING) && !bus.cfg_start;
  assign accept          = bus.cfg_ready && bus.cfg_valid;
  assign bus.cfg_error   = err_q;
  assign bus.table_ready = (state_q == READY);
  assign bus.M1          = m1_q;
  assign bus.M1_valid    = m1_valid_q;

  // Storage is deliberately not reset; only a complete load makes it visible.
  always_ff @(posedge clk) begin
    if (accept) table_q[idx_q] <= bus.cfg_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= EMPTY;
      idx_q      <= '0;
      err_q      <= 1'b0;
      m1_q       <= '0;
      m1_valid_q <= 1'b0;
    end else begin
      m1_valid_q <= 1'b0;
      if (state_q == READY && bus.M0_valid && !bus.cfg_start) begin
        m1_q       <= table_q[bus.M0];
        m1_valid_q <= 1'b1;
      end

      if (bus.cfg_start) begin
        state_q <= LOADING;
        idx_q   <= '0;
        err_q   <= 1'b0;
      end else if (accept) begin
        idx_q <= idx_q + IN_BITS'(1);
        if (idx_q == '1) begin
          state_q <= bus.cfg_last ? READY : EMPTY;
          err_q   <= !bus.cfg_last;
        end else if (bus.cfg_last) begin
          state_q <= EMPTY;
          err_q   <= 1'b1;
        end
      end
    end
  end
endmodule

// File: tb/tb_neuron_lut_loader.sv
// Self-checking bench for neuron_lut_loader: directed vectors, test-plan
// sequences and randomized traffic compared against a beat-counting model.
module tb_neuron_lut_loader;
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  neuron_lut_loader_if #(.IN_BITS(6), .OUT_BITS(2)) bus ();
  neuron_lut_loader #(.IN_BITS(6), .OUT_BITS(2)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int checks   = 0;
  int failures = 0;

  // Reference model: which phase we are in and how many entries have arrived.
  logic [1:0] mtab [64];
  int         n_beats;
  bit         loading, ready, err, mvr;
  logic [1:0] m1r;
  logic       last_rdy;

  typedef struct {
    bit s, v; logic [1:0] d; bit l, mv; logic [5:0] m;
    bit e_rdy, e_tr, e_err;
  } vec_t;

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic model_reset();
    loading = 0; ready = 0; err = 0; mvr = 0; m1r = 2'b00; n_beats = 0;
  endtask

  // One clock: drive, check cfg_ready mid-cycle, advance model, check registered outputs.
  task automatic cyc(input bit s, input bit v, input logic [1:0] d, input bit l,
                     input bit m0v, input logic [5:0] m);
    bus.cfg_start = s; bus.cfg_valid = v; bus.cfg_data = d; bus.cfg_last = l;
    bus.M0_valid = m0v; bus.M0 = m;
    @(negedge clk);
    last_rdy = bus.cfg_ready;
    chk("cfg_ready", 8'(bus.cfg_ready), 8'(loading && !s));
    @(posedge clk);
    if (s) begin
      loading = 1; ready = 0; err = 0; n_beats = 0; mvr = 0;
    end else begin
      mvr = ready && m0v;
      if (mvr) m1r = mtab[m];
      if (loading && v) begin
        mtab[n_beats] = d;
        n_beats++;
        if (l || n_beats == 64) begin
          loading = 0;
          if (l && n_beats == 64) ready = 1;
          else err = 1;
        end
      end
    end
    #1;
    chk("table_ready", 8'(bus.table_ready), 8'(ready));
    chk("cfg_error",   8'(bus.cfg_error),   8'(err));
    chk("M1_valid",    8'(bus.M1_valid),    8'(mvr));
    chk("M1",          8'(bus.M1),          8'(m1r));
  endtask

  task automatic idle();
    cyc(0, 0, 2'b00, 0, 1'($urandom_range(1)), 6'($urandom));
  endtask

  // mode 0: k[5:4], mode 1: ~k[1:0], mode 2: random. last_at<0 never asserts last.
  task automatic do_load(input int mode, input int nb, input int last_at,
                         input bit gapped, input bit with_start);
    logic [5:0] kv;
    logic [1:0] d;
    if (with_start) cyc(1, 0, 2'b00, 0, 0, 6'd0);
    for (int k = 0; k < nb; k++) begin
      if (gapped && (k % 3 == 2)) idle();
      kv = 6'(k);
      case (mode)
        0:       d = kv[5:4];
        1:       d = ~kv[1:0];
        default: d = 2'($urandom_range(3));
      endcase
      cyc(0, 1, d, k == last_at, 1'($urandom_range(1)), 6'($urandom));
    end
  endtask

  vec_t vecs [8];
  logic [5:0] iv;

  initial begin
    bus.cfg_start = 0; bus.cfg_valid = 0; bus.cfg_data = '0; bus.cfg_last = 0;
    bus.M0_valid = 0; bus.M0 = '0;
    rst_n = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    chk("rst_cfg_ready",   8'(bus.cfg_ready),   8'd0);
    chk("rst_table_ready", 8'(bus.table_ready), 8'd0);
    chk("rst_cfg_error",   8'(bus.cfg_error),   8'd0);
    chk("rst_M1",          8'(bus.M1),          8'd0);
    chk("rst_M1_valid",    8'(bus.M1_valid),    8'd0);
    rst_n = 1'b1;

    // Idle with lookups requested: nothing must be served.
    for (int i = 0; i < 10; i++) begin
      cyc(0, 0, 2'b00, 0, 1, 6'h3F);
      chk("idle_M1_valid", 8'(bus.M1_valid), 8'd0);
      chk("idle_M1",       8'(bus.M1),       8'd0);
    end

    // Start/restart/early-last corners from EMPTY.
    vecs[0] = '{s:0, v:1, d:2'd0, l:0, mv:1, m:6'h3F, e_rdy:0, e_tr:0, e_err:0};
    vecs[1] = '{s:1, v:1, d:2'd2, l:0, mv:0, m:6'h00, e_rdy:0, e_tr:0, e_err:0};
    vecs[2] = '{s:0, v:1, d:2'd1, l:1, mv:0, m:6'h00, e_rdy:1, e_tr:0, e_err:1};
    vecs[3] = '{s:0, v:0, d:2'd0, l:0, mv:1, m:6'h01, e_rdy:0, e_tr:0, e_err:1};
    vecs[4] = '{s:1, v:0, d:2'd0, l:0, mv:0, m:6'h00, e_rdy:0, e_tr:0, e_err:0};
    vecs[5] = '{s:0, v:0, d:2'd0, l:0, mv:0, m:6'h00, e_rdy:1, e_tr:0, e_err:0};
    vecs[6] = '{s:1, v:1, d:2'd3, l:1, mv:0, m:6'h00, e_rdy:0, e_tr:0, e_err:0};
    vecs[7] = '{s:0, v:0, d:2'd0, l:0, mv:0, m:6'h00, e_rdy:1, e_tr:0, e_err:0};
    foreach (vecs[i]) begin
      cyc(vecs[i].s, vecs[i].v, vecs[i].d, vecs[i].l, vecs[i].mv, vecs[i].m);
      chk("vec_cfg_ready",   8'(last_rdy),        8'(vecs[i].e_rdy));
      chk("vec_table_ready", 8'(bus.table_ready), 8'(vecs[i].e_tr));
      chk("vec_cfg_error",   8'(bus.cfg_error),   8'(vecs[i].e_err));
    end

    // Full gapped load of k[5:4], single lookup, then back-to-back sweep.
    do_load(0, 64, 63, 1, 1);
    chk("load_table_ready", 8'(bus.table_ready), 8'd1);
    cyc(0, 0, 2'b00, 0, 1, 6'b110011);
    chk("lookup_33_M1",       8'(bus.M1),       8'h3);
    chk("lookup_33_M1_valid", 8'(bus.M1_valid), 8'd1);
    for (int i = 0; i < 64; i++) begin
      iv = 6'(i);
      cyc(0, 0, 2'b00, 0, 1, iv);
      chk("sweep_M1", 8'(bus.M1), 8'(iv[5:4]));
      chk("sweep_M1_valid", 8'(bus.M1_valid), 8'd1);
    end

    // Framing error: last on beat 10, then start clears the error.
    do_load(0, 11, 10, 0, 1);
    chk("frame_cfg_error",   8'(bus.cfg_error),   8'd1);
    chk("frame_table_ready", 8'(bus.table_ready), 8'd0);
    cyc(1, 0, 2'b00, 0, 0, 6'd0);
    chk("frame_clear_error", 8'(bus.cfg_error), 8'd0);

    // Missing last on beat 63.
    do_load(2, 64, -1, 0, 0);
    chk("nolast_cfg_error",   8'(bus.cfg_error),   8'd1);
    chk("nolast_table_ready", 8'(bus.table_ready), 8'd0);
    idle();
    chk("nolast_cfg_ready", 8'(last_rdy), 8'd0);

    // Reload from READY with a colliding start+valid beat.
    do_load(0, 64, 63, 0, 1);
    chk("reload_pre_ready", 8'(bus.table_ready), 8'd1);
    cyc(1, 1, 2'b11, 0, 1, 6'h05);
    chk("reload_tr_drop", 8'(bus.table_ready), 8'd0);
    chk("reload_no_serve", 8'(bus.M1_valid), 8'd0);
    do_load(1, 64, 63, 0, 0);
    cyc(0, 0, 2'b00, 0, 1, 6'h05);
    chk("reload_lookup_05", 8'(bus.M1), 8'h2);

    // Asynchronous reset in the middle of a load.
    do_load(2, 30, -1, 0, 1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_cfg_ready",   8'(bus.cfg_ready),   8'd0);
    chk("arst_table_ready", 8'(bus.table_ready), 8'd0);
    chk("arst_cfg_error",   8'(bus.cfg_error),   8'd0);
    chk("arst_M1",          8'(bus.M1),          8'd0);
    chk("arst_M1_valid",    8'(bus.M1_valid),    8'd0);
    model_reset();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) cyc(0, 1, 2'b01, 0, 1, 6'($urandom));

    // Randomized traffic: starts, gaps, early/missing lasts and lookups.
    for (int i = 0; i < 4000; i++) begin
      bit s, l;
      s = ($urandom_range(249) == 0);
      if (n_beats == 63) l = ($urandom_range(9) != 0);
      else               l = ($urandom_range(299) == 0);
      if (!loading && !ready && $urandom_range(19) == 0) s = 1;
      if (ready && $urandom_range(99) == 0) s = 1;
      cyc(s, ($urandom_range(9) < 7), 2'($urandom_range(3)), l,
          1'($urandom_range(1)), 6'($urandom));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
